// File: rtl/uart_rx.sv
// UART receiver: 3-flop synchronized input, mid-bit sampling, optional even/odd parity.
// Outputs register one cycle after the stop-bit sample; there is no backpressure, so every frame is reported.
module uart_rx #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_TYPE      = 0,
  parameter int CLOCKS_PER_BIT   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] received_data,
  output logic                        data_is_valid,
  output logic                        rx_error
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);
  localparam int IDX_W = $clog2(INPUT_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(INPUT_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT} state_t;

  state_t                      state_q;
  logic [2:0]                  sync_q;
  logic                        line_prev_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, data_q;
  logic                        par_err_q, stop_ok_q, frame_done_q, valid_q, err_q;
  logic                        line, sample, exp_parity;

  assign line       = sync_q[2];
  assign sample     = (state_q != IDLE) && (cnt_q == SAMPLE_AT);
  assign cnt_d      = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_ONE;
  assign exp_parity = (PARITY_TYPE == 0) ? ^shift_q : ~^shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= 3'b111;
      line_prev_q  <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      par_err_q    <= 1'b0;
      stop_ok_q    <= 1'b0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], serial_in};
      line_prev_q  <= line;
      frame_done_q <= 1'b0;
      valid_q      <= frame_done_q & stop_ok_q & ~par_err_q;
      err_q        <= frame_done_q & ~(stop_ok_q & ~par_err_q);
      if (frame_done_q && stop_ok_q && !par_err_q) data_q <= shift_q;
      // The counter free-runs modulo CLOCKS_PER_BIT once a frame starts, so one compare hits every mid-bit.
      cnt_q <= (state_q == IDLE) ? '0 : cnt_d;
      case (state_q)
        IDLE: if (line_prev_q && !line) state_q <= START_BIT;
        START_BIT: if (sample) begin
          if (!line) begin
            state_q   <= DATA_BITS;
            idx_q     <= '0;
            par_err_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        DATA_BITS: if (sample) begin
          shift_q <= {line, shift_q[INPUT_DATA_WIDTH-1:1]};
          idx_q   <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) state_q <= (PARITY_ENABLED != 0) ? PARITY_BIT : STOP_BIT;
        end
        PARITY_BIT: if (sample) begin
          par_err_q <= (line != exp_parity);
          state_q   <= STOP_BIT;
        end
        STOP_BIT: if (sample) begin
          stop_ok_q    <= line;
          frame_done_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign received_data = data_q;
  assign data_is_valid = valid_q;
  assign rx_error      = err_q;

endmodule
